// File: rtl/stash_scan_drain.sv
// stash_scan_drain
//   Drains the per-access scan table after the scan phase. Entries
//   0..BlocksOnPath-1 are walked root bucket first. Each entry is read, then
//   cleared to SNULL in the following cycle. One writeback descriptor per
//   path slot is emitted through a 2-entry valid/ready output buffer.
//
// Optional feature macro: STASH_DRAIN_STATS_EN
//   When defined, adds o_real_count / o_dummy_count handshake counters.
//
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                begin a drain (sampled only in IDLE)
//   i_table_ready          scan table has finished its own reset
//   o_dma_addr             scan-table address
//   o_dma_valid            read strobe; i_dma_data is valid the next cycle
//   o_dma_reset            write-SNULL strobe
//   i_dma_data             scan-table read data
//   o_out_saddr            stash entry address (SNULL for a dummy slot)
//   o_out_dummy            slot holds no real block
//   o_out_bucket_last      last slot of a bucket
//   o_out_valid            descriptor valid
//   i_out_ready            downstream accepts the descriptor
//   o_busy                 drain in progress
//   o_done                 one-cycle completion pulse
//   o_real_count           (STASH_DRAIN_STATS_EN) real descriptors handed off
//   o_dummy_count          (STASH_DRAIN_STATS_EN) dummy descriptors handed off

module stash_scan_drain #(
    parameter int unsigned ORAML           = 3,
    parameter int unsigned ORAMZ           = 4,
    parameter int unsigned StashEAWidth    = 8,
    parameter int unsigned ScanTableAWidth = 5,
    parameter int unsigned BlocksOnPath    = ORAMZ * (ORAML + 1),
    parameter logic [StashEAWidth-1:0] SNULL = {StashEAWidth{1'b1}}
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_table_ready,
    output logic [ScanTableAWidth-1:0] o_dma_addr,
    output logic                       o_dma_valid,
    output logic                       o_dma_reset,
    input  logic [StashEAWidth-1:0]    i_dma_data,
    output logic [StashEAWidth-1:0]    o_out_saddr,
    output logic                       o_out_dummy,
    output logic                       o_out_bucket_last,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic                       o_busy,
`ifdef STASH_DRAIN_STATS_EN
    output logic [ScanTableAWidth-1:0] o_real_count,
    output logic [ScanTableAWidth-1:0] o_dummy_count,
`endif
    output logic                       o_done
);

    localparam int unsigned SlotW = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
    localparam logic [ScanTableAWidth-1:0] LastIdx  = ScanTableAWidth'(BlocksOnPath - 1);
    localparam logic [SlotW-1:0]           LastSlot = SlotW'(ORAMZ - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_CLEAR = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // FSM and control registers
    logic [2:0]                 r_state;
    logic [2:0]                 w_state_nxt;
    logic [ScanTableAWidth-1:0] r_idx;
    logic [ScanTableAWidth-1:0] w_idx_nxt;
    logic [SlotW-1:0]           r_slot;
    logic [SlotW-1:0]           w_slot_nxt;
    logic                       r_wait;
    logic                       w_wait_nxt;
    logic                       r_dma_valid;
    logic                       w_dma_valid_nxt;
    logic                       r_dma_reset;
    logic                       w_dma_reset_nxt;
    logic                       r_busy;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       w_stats_clr;

    // Output buffer: head entry drives the outputs, r_q1_* is the second slot
    logic [1:0]                 r_cnt;
    logic [1:0]                 w_cnt_nxt;
    logic [1:0]                 w_cnt_after_pop;
    logic                       w_push;
    logic                       w_pop;
    logic                       r_out_valid;
    logic [StashEAWidth-1:0]    r_out_saddr;
    logic                       r_out_dummy;
    logic                       r_out_last;
    logic [StashEAWidth-1:0]    r_q1_saddr;
    logic                       r_q1_dummy;
    logic                       r_q1_last;
    logic                       w_in_dummy;
    logic                       w_in_last;

    assign w_pop           = r_out_valid & i_out_ready;
    assign w_cnt_after_pop = r_cnt - 2'(w_pop);
    assign w_cnt_nxt       = r_cnt + 2'(w_push) - 2'(w_pop);
    assign w_in_dummy      = (i_dma_data == SNULL);
    assign w_in_last       = (r_slot == LastSlot);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_slot_nxt      = r_slot;
        w_wait_nxt      = r_wait;
        w_dma_valid_nxt = 1'b0;
        w_dma_reset_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_push          = 1'b0;
        w_stats_clr     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // a Start without TableReady is dropped, not remembered
                if (i_start && i_table_ready) begin
                    w_state_nxt     = ST_READ;
                    w_idx_nxt       = '0;
                    w_slot_nxt      = '0;
                    w_wait_nxt      = 1'b0;
                    w_dma_valid_nxt = 1'b1;
                    w_stats_clr     = 1'b1;
                end
            end

            ST_READ: begin
                if (r_wait) begin
                    // gated: issue the read only once the buffer drops to <=1
                    if (w_cnt_after_pop <= 2'd1) begin
                        w_wait_nxt      = 1'b0;
                        w_dma_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt     = ST_CLEAR;
                    w_dma_reset_nxt = 1'b1;
                end
            end

            ST_CLEAR: begin
                w_push     = 1'b1;
                w_slot_nxt = (r_slot == LastSlot) ? '0 : r_slot + SlotW'(1);
                if (r_idx == LastIdx) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_idx_nxt   = r_idx + ScanTableAWidth'(1);
                    w_state_nxt = ST_READ;
                    // the push this cycle must leave at most one entry buffered
                    if (w_cnt_after_pop == 2'd0) begin
                        w_dma_valid_nxt = 1'b1;
                        w_wait_nxt      = 1'b0;
                    end else begin
                        w_wait_nxt      = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered control outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_slot      <= '0;
            r_wait      <= 1'b0;
            r_dma_valid <= 1'b0;
            r_dma_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_slot      <= w_slot_nxt;
            r_wait      <= w_wait_nxt;
            r_dma_valid <= w_dma_valid_nxt;
            r_dma_reset <= w_dma_reset_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    // Two-entry output buffer; head is held while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_saddr <= SNULL;
            r_out_dummy <= 1'b1;
            r_out_last  <= 1'b0;
            r_q1_saddr  <= SNULL;
            r_q1_dummy  <= 1'b1;
            r_q1_last   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= (w_cnt_nxt != 2'd0);
            if (w_pop && (r_cnt == 2'd2)) begin
                r_out_saddr <= r_q1_saddr;
                r_out_dummy <= r_q1_dummy;
                r_out_last  <= r_q1_last;
            end
            if (w_push) begin
                if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)) begin
                    r_out_saddr <= i_dma_data;
                    r_out_dummy <= w_in_dummy;
                    r_out_last  <= w_in_last;
                end else begin
                    r_q1_saddr  <= i_dma_data;
                    r_q1_dummy  <= w_in_dummy;
                    r_q1_last   <= w_in_last;
                end
            end
        end
    end

`ifdef STASH_DRAIN_STATS_EN
    // Handshake counters, cleared when a drain is accepted
    logic [ScanTableAWidth-1:0] r_real_cnt;
    logic [ScanTableAWidth-1:0] r_dummy_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_real_cnt  <= '0;
            r_dummy_cnt <= '0;
        end else if (w_stats_clr) begin
            r_real_cnt  <= '0;
            r_dummy_cnt <= '0;
        end else if (w_pop) begin
            if (r_out_dummy) begin
                r_dummy_cnt <= r_dummy_cnt + ScanTableAWidth'(1);
            end else begin
                r_real_cnt  <= r_real_cnt + ScanTableAWidth'(1);
            end
        end
    end

    assign o_real_count  = r_real_cnt;
    assign o_dummy_count = r_dummy_cnt;
`endif

    assign o_dma_addr        = r_idx;
    assign o_dma_valid       = r_dma_valid;
    assign o_dma_reset       = r_dma_reset;
    assign o_out_saddr       = r_out_saddr;
    assign o_out_dummy       = r_out_dummy;
    assign o_out_bucket_last = r_out_last;
    assign o_out_valid       = r_out_valid;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

endmodule

// File: tb/tb_stash_scan_drain.sv
// tb_stash_scan_drain
//   Self-checking bench for stash_scan_drain with default parameters. A
//   behavioural scan table answers the DMA port; expected descriptors are
//   derived from a snapshot of the table contents taken before each drain.

module tb_stash_scan_drain;

    localparam int unsigned BOP = 16;
    localparam int unsigned Z   = 4;
    localparam logic [7:0]  SN  = 8'hFF;

    typedef struct packed {
        logic [7:0] a;
        logic       d;
        logic       l;
    } desc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_table_ready = 1'b0;
    logic       i_out_ready = 1'b1;
    logic [4:0] o_dma_addr;
    logic       o_dma_valid;
    logic       o_dma_reset;
    logic [7:0] tbl_rdata = 8'h00;
    logic [7:0] o_out_saddr;
    logic       o_out_dummy;
    logic       o_out_bucket_last;
    logic       o_out_valid;
    logic       o_busy;
    logic       o_done;
`ifdef STASH_DRAIN_STATS_EN
    logic [4:0] real_cnt;
    logic [4:0] dummy_cnt;
`endif

    always #5 clk = ~clk;

    stash_scan_drain dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (i_start),
        .i_table_ready     (i_table_ready),
        .o_dma_addr        (o_dma_addr),
        .o_dma_valid       (o_dma_valid),
        .o_dma_reset       (o_dma_reset),
        .i_dma_data        (tbl_rdata),
        .o_out_saddr       (o_out_saddr),
        .o_out_dummy       (o_out_dummy),
        .o_out_bucket_last (o_out_bucket_last),
        .o_out_valid       (o_out_valid),
        .i_out_ready       (i_out_ready),
        .o_busy            (o_busy),
`ifdef STASH_DRAIN_STATS_EN
        .o_real_count      (real_cnt),
        .o_dummy_count     (dummy_cnt),
`endif
        .o_done            (o_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scan table: registered read, SNULL write
    logic [7:0] mem [0:31];
    always @(posedge clk) begin
        if (o_dma_valid) tbl_rdata <= mem[o_dma_addr];
        if (o_dma_reset) mem[o_dma_addr] = SN;
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = 1'($urandom_range(0, 1));
            default: i_out_ready = 1'b0;
        endcase
    end

    // Monitor: collects descriptors and tracks protocol invariants
    desc_t got[$];
    desc_t exp_q[$];
    bit    mon_en = 1'b0;
    int    clr_seen, hs_seen, rd_seen, done_seen, max_occ;
    int    viol_coll, viol_full, viol_valid, viol_hold;
    int    first_valid_cyc, done_cyc;
    bit    prev_stall;
    desc_t prev_d;

    always @(negedge clk) begin : monitor
        int    occ;
        desc_t cur;
        if (mon_en) begin
            cur = {o_out_saddr, o_out_dummy, o_out_bucket_last};
            occ = clr_seen - hs_seen;
            if (occ > max_occ) max_occ = occ;
            if (o_dma_valid && o_dma_reset) viol_coll++;
            if (o_dma_valid && occ > 1) viol_full++;
            if (o_out_valid !== (occ != 0)) viol_valid++;
            if (prev_stall && (!o_out_valid || cur !== prev_d)) viol_hold++;
            if (o_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (o_done) begin done_seen++; done_cyc = cyc; end
            if (o_dma_valid) rd_seen++;
            if (o_dma_reset) clr_seen++;
            if (o_out_valid && i_out_ready) begin got.push_back(cur); hs_seen++; end
            prev_stall = o_out_valid && !i_out_ready;
            prev_d     = cur;
        end
    end

    task automatic clear_mon();
        got.delete();
        clr_seen = 0; hs_seen = 0; rd_seen = 0; done_seen = 0; max_occ = 0;
        viol_coll = 0; viol_full = 0; viol_valid = 0; viol_hold = 0;
        first_valid_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
    endtask

    // Reference: slot i carries the stored address, dummy iff SNULL, last iff i mod Z == Z-1
    task automatic snap_exp();
        exp_q.delete();
        for (int i = 0; i < BOP; i++)
            exp_q.push_back({mem[i], (mem[i] == SN), ((i % Z) == Z - 1)});
    endtask

    task automatic fill_table(input int pct);
        for (int i = 0; i < 32; i++) mem[i] = SN;
        for (int i = 0; i < BOP; i++)
            if ($urandom_range(0, 99) < pct) mem[i] = 8'($urandom_range(0, 254));
    endtask

    function automatic int first_bad();
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int table_dirty();
        int n = 0;
        for (int i = 0; i < BOP; i++) if (mem[i] !== SN) n++;
        return n;
    endfunction

    function automatic int viol_sum();
        return viol_coll + viol_full + viol_valid + viol_hold;
    endfunction

    task automatic pulse_start(output int sc);
        @(posedge clk); #1;
        i_start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_seen == 0 && n < budget) begin @(posedge clk); n++; end
        total++;
        if (done_seen == 0) begin
            bad++;
            $display("FAIL %s_timeout: no Done within %0d cycles, required one", tag, budget);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 9;
        if (o_busy !== 1'b0)            begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0)            begin bad++; $display("FAIL rst_done: got %b want 0", o_done); end
        if (o_out_valid !== 1'b0)       begin bad++; $display("FAIL rst_valid: got %b want 0", o_out_valid); end
        if (o_dma_valid !== 1'b0)       begin bad++; $display("FAIL rst_dma_valid: got %b want 0", o_dma_valid); end
        if (o_dma_reset !== 1'b0)       begin bad++; $display("FAIL rst_dma_reset: got %b want 0", o_dma_reset); end
        if (o_dma_addr !== 5'd0)        begin bad++; $display("FAIL rst_dma_addr: got %0d want 0", o_dma_addr); end
        if (o_out_saddr !== SN)         begin bad++; $display("FAIL rst_saddr: got %h want %h", o_out_saddr, SN); end
        if (o_out_dummy !== 1'b1)       begin bad++; $display("FAIL rst_dummy: got %b want 1", o_out_dummy); end
        if (o_out_bucket_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", o_out_bucket_last); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_table_ready = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int sc, k;
        for (int i = 0; i < 32; i++) mem[i] = SN;
        mem[0] = 8'h10;
        mem[5] = 8'h23;
        rdy_mode = 0;
        snap_exp();
        clear_mon();
        pulse_start(sc);
        wait_done("basic", 200);
        total += 7;
        if (first_valid_cyc !== sc + 3) begin bad++; $display("FAIL basic_first_valid: cycle %0d want %0d", first_valid_cyc, sc + 3); end
        if (done_cyc !== sc + 35)       begin bad++; $display("FAIL basic_done_time: cycle %0d want %0d", done_cyc, sc + 35); end
        if (got.size() !== BOP)         begin bad++; $display("FAIL basic_count: got %0d want %0d", got.size(), BOP); end
        k = first_bad();
        if (k !== -1)                   begin bad++; $display("FAIL basic_desc[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        if (done_seen !== 1)            begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_seen); end
        if (viol_sum() !== 0)           begin bad++; $display("FAIL basic_protocol: coll=%0d full=%0d valid=%0d hold=%0d want 0", viol_coll, viol_full, viol_valid, viol_hold); end
        if (table_dirty() !== 0)        begin bad++; $display("FAIL basic_table_clear: %0d entries not SNULL, want 0", table_dirty()); end
    endtask

    task automatic test_random();
        int sc, k;
        for (int it = 0; it < 4; it++) begin
            fill_table(35);
            rdy_mode = 1;
            snap_exp();
            clear_mon();
            pulse_start(sc);
            wait_done("random", 400);
            total += 5;
            if (got.size() !== BOP)  begin bad++; $display("FAIL random%0d_count: got %0d want %0d", it, got.size(), BOP); end
            k = first_bad();
            if (k !== -1)            begin bad++; $display("FAIL random%0d_desc[%0d]: got %h want %h", it, k, got[k], exp_q[k]); end
            if (done_seen !== 1)     begin bad++; $display("FAIL random%0d_done_count: got %0d want 1", it, done_seen); end
            if (viol_sum() !== 0)    begin bad++; $display("FAIL random%0d_protocol: coll=%0d full=%0d valid=%0d hold=%0d want 0", it, viol_coll, viol_full, viol_valid, viol_hold); end
            if (table_dirty() !== 0) begin bad++; $display("FAIL random%0d_table_clear: %0d dirty, want 0", it, table_dirty()); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_backpressure();
        int sc, k, n;
        fill_table(50);
        snap_exp();
        clear_mon();
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        pulse_start(sc);
        n = 0;
        while (first_valid_cyc < 0 && n < 50) begin @(posedge clk); n++; end
        repeat (10) @(posedge clk);
        rdy_mode = 0;
        wait_done("bp", 300);
        total += 5;
        if (max_occ !== 2)      begin bad++; $display("FAIL bp_max_buffered: got %0d want 2", max_occ); end
        if (viol_sum() !== 0)   begin bad++; $display("FAIL bp_protocol: coll=%0d full=%0d valid=%0d hold=%0d want 0", viol_coll, viol_full, viol_valid, viol_hold); end
        if (got.size() !== BOP) begin bad++; $display("FAIL bp_count: got %0d want %0d", got.size(), BOP); end
        k = first_bad();
        if (k !== -1)           begin bad++; $display("FAIL bp_desc[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        if (done_seen !== 1)    begin bad++; $display("FAIL bp_done_count: got %0d want 1", done_seen); end
    endtask

    task automatic test_not_ready();
        int sc;
        fill_table(50);
        clear_mon();
        i_table_ready = 1'b0;
        pulse_start(sc);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL nr_busy_blocked: got %b want 0", o_busy); end
        @(posedge clk); #1;
        i_table_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (o_busy !== 1'b0)  begin bad++; $display("FAIL nr_busy_after_ready: got %b want 0", o_busy); end
        if (rd_seen !== 0)    begin bad++; $display("FAIL nr_reads: got %0d want 0", rd_seen); end
        if (got.size() !== 0) begin bad++; $display("FAIL nr_desc: got %0d want 0", got.size()); end
    endtask

    task automatic test_start_busy();
        int sc, dummy_sc, k;
        fill_table(40);
        rdy_mode = 1;
        snap_exp();
        clear_mon();
        pulse_start(sc);
        fork
            wait_done("busy", 400);
            begin
                for (int p = 0; p < 3; p++) begin
                    repeat (6) @(posedge clk);
                    pulse_start(dummy_sc);
                end
            end
        join
        repeat (20) @(posedge clk);
        rdy_mode = 0;
        total += 3;
        if (got.size() !== BOP) begin bad++; $display("FAIL busy_count: got %0d want %0d", got.size(), BOP); end
        k = first_bad();
        if (k !== -1)           begin bad++; $display("FAIL busy_desc[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        if (done_seen !== 1)    begin bad++; $display("FAIL busy_done_count: got %0d want 1", done_seen); end
    endtask

    task automatic test_reset_mid();
        int sc, k, n, w;
        fill_table(50);
        rdy_mode = 0;
        clear_mon();
        pulse_start(sc);
        n = 0; w = 0;
        while (n < 5 && w < 100) begin
            @(negedge clk);
            if (o_dma_reset) n++;
            w++;
        end
        total++;
        if (n !== 5) begin bad++; $display("FAIL mid_fifth_clear: saw %0d clears want 5", n); end
        #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        i_table_ready = 1'b0;
        #1;
        total += 9;
        if (o_busy !== 1'b0)            begin bad++; $display("FAIL mid_busy: got %b want 0", o_busy); end
        if (o_done !== 1'b0)            begin bad++; $display("FAIL mid_done: got %b want 0", o_done); end
        if (o_out_valid !== 1'b0)       begin bad++; $display("FAIL mid_valid: got %b want 0", o_out_valid); end
        if (o_dma_valid !== 1'b0)       begin bad++; $display("FAIL mid_dma_valid: got %b want 0", o_dma_valid); end
        if (o_dma_reset !== 1'b0)       begin bad++; $display("FAIL mid_dma_reset: got %b want 0", o_dma_reset); end
        if (o_dma_addr !== 5'd0)        begin bad++; $display("FAIL mid_dma_addr: got %0d want 0", o_dma_addr); end
        if (o_out_saddr !== SN)         begin bad++; $display("FAIL mid_saddr: got %h want %h", o_out_saddr, SN); end
        if (o_out_dummy !== 1'b1)       begin bad++; $display("FAIL mid_dummy: got %b want 1", o_out_dummy); end
        if (o_out_bucket_last !== 1'b0) begin bad++; $display("FAIL mid_last: got %b want 0", o_out_bucket_last); end
        repeat (3) @(posedge clk); #1;
        // table's own reset, then a new access fills it again
        fill_table(50);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        i_table_ready = 1'b1;
        snap_exp();
        clear_mon();
        mon_en = 1'b1;
        pulse_start(sc);
        wait_done("mid", 200);
        total += 5;
        if (first_valid_cyc !== sc + 3) begin bad++; $display("FAIL mid_first_valid: cycle %0d want %0d", first_valid_cyc, sc + 3); end
        if (got.size() !== BOP)         begin bad++; $display("FAIL mid_count: got %0d want %0d", got.size(), BOP); end
        k = first_bad();
        if (k !== -1)                   begin bad++; $display("FAIL mid_desc[%0d]: got %h want %h", k, got[k], exp_q[k]); end
        if (done_seen !== 1)            begin bad++; $display("FAIL mid_done_count: got %0d want 1", done_seen); end
        if (table_dirty() !== 0)        begin bad++; $display("FAIL mid_table_clear: %0d dirty, want 0", table_dirty()); end
    endtask

`ifdef STASH_DRAIN_STATS_EN
    task automatic test_stats();
        int sc, placed, a;
        for (int i = 0; i < 32; i++) mem[i] = SN;
        placed = 0;
        while (placed < 3) begin
            a = $urandom_range(0, BOP - 1);
            if (mem[a] == SN) begin mem[a] = 8'($urandom_range(0, 254)); placed++; end
        end
        rdy_mode = 1;
        clear_mon();
        pulse_start(sc);
        wait_done("stats", 400);
        rdy_mode = 0;
        total += 2;
        if (real_cnt !== 5'd3)   begin bad++; $display("FAIL stats_real: got %0d want 3", real_cnt); end
        if (dummy_cnt !== 5'd13) begin bad++; $display("FAIL stats_dummy: got %0d want 13", dummy_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = SN;
        clear_mon();
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_not_ready();
        test_start_busy();
        test_reset_mid();
`ifdef STASH_DRAIN_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
